uart_byte_receiver: RTL
=======================

Name: uart_byte_receiver

Overview:
- Serial-to-byte front end for the Uniboard command link. Sits directly upstream of the protocol interface.
- Converts the host UART line (8N1, LSB first, idle high) into a parallel byte plus a data-ready level.
- The protocol interface's state machine waits for drdy high, consumes data, then waits for drdy low.
- Adds glitch rejection and framing-error reporting so corrupt frames never reach the command parser.

Parameters:
- BAUD_DIV, 2083, clk_12MHz cycles per bit. Must be >= 8. Bench uses 12.
- DRDY_CYCLES, 4, number of clock cycles drdy stays high per received byte. Must satisfy 2 <= DRDY_CYCLES < BAUD_DIV.

Ports:
- clk_12MHz  input  1  module clock; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset
- rx  input  1  raw UART line from host, asynchronous to clk_12MHz
- data  output  8  last correctly framed byte
- drdy  output  1  high for DRDY_CYCLES cycles after each good byte
- frame_err  output  1  one-cycle pulse on a bad stop bit
- busy  output  1  high while a frame is being received (START through STOP)

Behaviour:
- **Clocking and reset.** One clock, clk_12MHz. reset_n is asynchronous and active-low. While reset_n = 0:
  - state = IDLE
  - data = 8'h00, drdy = 0, frame_err = 0, busy = 0
  - both synchronizer flops = 1
  - bit counter and shift register = 0
  - Reset asserted mid-frame aborts the frame with no drdy and no frame_err.
- **Input synchronizer.** rx passes through 2 flops to give rx_s. All decisions use rx_s only.
- **Bit timer.** baud_cnt is $clog2(BAUD_DIV) bits wide and counts 0..BAUD_DIV-1. bit_idx is 3 bits.
- **IDLE.**
  - rx_s = 0 → START, baud_cnt = 0, busy = 1.
- **START.**
  - When baud_cnt = BAUD_DIV/2 - 1 (integer division), sample rx_s:
    - rx_s = 1 → glitch: back to IDLE, busy = 0, no outputs change.
    - rx_s = 0 → DATA, baud_cnt = 0, bit_idx = 0.
- **DATA.**
  - When baud_cnt = BAUD_DIV-1, shift rx_s into the shift register MSB-side (LSB-first serial order), then baud_cnt = 0.
  - After bit_idx = 7 is sampled → STOP. Otherwise bit_idx++.
- **STOP.** When baud_cnt = BAUD_DIV-1, sample rx_s:
  - rx_s = 1 → good frame:
    - data <= shift register
    - drdy high starting next cycle for exactly DRDY_CYCLES cycles
    - → IDLE, busy = 0
  - rx_s = 0 → bad frame:
    - frame_err = 1 for one cycle; data and drdy unchanged
    - → BREAK
- **BREAK.**
  - Stay until rx_s = 1, then → IDLE, busy = 0.
  - A held-low line (break) yields exactly one frame_err.
- **Data hold.** data changes only on a good stop bit. It is stable while drdy is high and until the next good frame.
- **Latency.** drdy rises 2 (sync) + BAUD_DIV/2 + 9*BAUD_DIV + 1 cycles after the rx falling edge, ±1 cycle of sync phase.
- **Back-to-back frames.**
  - Return to IDLE at the stop-bit midpoint, so the next start edge is caught with no gap.
  - The drdy hold counter runs independently of the FSM.
  - DRDY_CYCLES < BAUD_DIV guarantees drdy has fallen before the next byte can complete.
- **Output drive.** All outputs are registered; none are combinational from rx.

Decomposition:
- Shared package uniboard_pkg holds:
  - uart_rx_state_t enum: IDLE, START, DATA, STOP, BREAK
  - protocol byte constants START_BYTE 8'h01, END_BYTE 8'h17, ESC_BYTE 8'h1B, for the bench and the protocol interface
- One sub-module, sync_2ff: a 2-flop synchronizer with reset value parameter RESET_VAL, default 1. It is reused later for limit/encoder inputs.

Test Plan (BAUD_DIV=12, DRDY_CYCLES=4):
- Send 8'hA5 as a clean 8N1 frame → drdy high exactly 4 cycles; data = 8'hA5 from the first drdy cycle until the next good frame; frame_err never asserted.
- Send 8'h01, 8'h17, 8'h1B back-to-back with zero idle bits → three drdy pulses; data = 01, 17, 1B respectively; each pulse separated by 120 ± 1 cycles.
- Drive rx low for 4 cycles then high (glitch shorter than half a bit) → returns to IDLE; no drdy; no frame_err; busy high for at most 8 cycles; data unchanged.
- Send 8'h3C with the stop bit forced low, then hold rx low for 40 cycles → one frame_err pulse; no drdy; data keeps its previous value; busy clears only after rx returns high.
- Assert reset_n = 0 for 3 cycles during data bit 4 of 8'hFF, then send 8'h5A → no output from the aborted frame; all outputs 0 during reset; 8'h5A received correctly with a 4-cycle drdy.

Source files
------------

// File: rtl/uniboard_pkg.sv
// Shared types and constants for the Uniboard command link: UART receiver
// states and the protocol framing bytes seen by the protocol interface.
package uniboard_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam logic [7:0] START_BYTE = 8'h01;
    localparam logic [7:0] END_BYTE   = 8'h17;
    localparam logic [7:0] ESC_BYTE   = 8'h1B;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// chosen so an idle line (or an inactive limit/encoder input) reads correctly.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {2{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_byte_receiver.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error
// pulse with break handling, and a fixed-length drdy level per good byte.
module uart_byte_receiver
    import uniboard_pkg::*;
#(
    parameter int BAUD_DIV    = 2083,
    parameter int DRDY_CYCLES = 4
) (
    input  logic       clk_12MHz,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] data,
    output logic       drdy,
    output logic       frame_err,
    output logic       busy
);

    localparam int CNT_W  = $clog2(BAUD_DIV);
    localparam int DRDY_W = (DRDY_CYCLES > 1) ? $clog2(DRDY_CYCLES) : 1;

    localparam logic [CNT_W-1:0]  CNT_ZERO  = '0;
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [DRDY_W-1:0] DRDY_ONE  = DRDY_W'(1);
    localparam logic [DRDY_W-1:0] DRDY_LAST = DRDY_W'(DRDY_CYCLES - 1);

    logic rx_s;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_rx_sync (
        .clk_i (clk_12MHz),
        .rst_ni(reset_n),
        .d_i   (rx),
        .q_o   (rx_s)
    );

    uart_rx_state_t   state_q;
    logic [CNT_W-1:0] baud_cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             frame_err_q;
    logic             busy_q;
    logic             good_stop;

    assign good_stop = (state_q == STOP) && (baud_cnt_q == CNT_LAST) && rx_s;

    always_ff @(posedge clk_12MHz or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            baud_cnt_q  <= CNT_ZERO;
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'h00;
            data_q      <= 8'h00;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!rx_s) begin
                        state_q    <= START;
                        baud_cnt_q <= CNT_ZERO;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt_q == CNT_MID) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q    <= DATA;
                            baud_cnt_q <= CNT_ZERO;
                            bit_idx_q  <= 3'd0;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
                DATA: begin
                    // Counter was re-zeroed at the start-bit midpoint, so every
                    // wrap lands in the middle of a data bit.
                    if (baud_cnt_q == CNT_LAST) begin
                        shift_q    <= {rx_s, shift_q[7:1]};
                        baud_cnt_q <= CNT_ZERO;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
                STOP: begin
                    if (baud_cnt_q == CNT_LAST) begin
                        baud_cnt_q <= CNT_ZERO;
                        if (rx_s) begin
                            data_q  <= shift_q;
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        baud_cnt_q <= baud_cnt_q + CNT_ONE;
                    end
                end
                BREAK: begin
                    if (rx_s) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // drdy hold timer is decoupled from the FSM so a new frame can start
    // while drdy is still high.
    logic              drdy_q, drdy_d;
    logic [DRDY_W-1:0] drdy_cnt_q, drdy_cnt_d;

    always_comb begin
        drdy_d     = drdy_q;
        drdy_cnt_d = drdy_cnt_q;
        if (good_stop) begin
            drdy_d     = 1'b1;
            drdy_cnt_d = DRDY_LAST;
        end else if (drdy_q) begin
            if (drdy_cnt_q == '0) begin
                drdy_d = 1'b0;
            end else begin
                drdy_cnt_d = drdy_cnt_q - DRDY_ONE;
            end
        end
    end

    always_ff @(posedge clk_12MHz or negedge reset_n) begin
        if (!reset_n) begin
            drdy_q     <= 1'b0;
            drdy_cnt_q <= '0;
        end else begin
            drdy_q     <= drdy_d;
            drdy_cnt_q <= drdy_cnt_d;
        end
    end

    assign data      = data_q;
    assign drdy      = drdy_q;
    assign frame_err = frame_err_q;
    assign busy      = busy_q;

endmodule
